// File: rtl/pc_seq.sv
// Program-counter sequencer: owns PC and runs a BOOT/FETCH/EXEC/HALT loop
// against a variable-latency instruction port, halting on misalignment or fetch timeout.
module pc_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   output logic        if_req,
   output logic [31:0] if_addr,
   input  logic        if_ack,
   input  logic [31:0] if_rdata,
   input  logic        is_branch,
   input  logic        br_taken,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic        stall,
   input  logic [31:0] npc_in,
   output logic [1:0]  npc_op,
   output logic [31:0] pc,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic        misalign_exc,
   output logic        fetch_err,
   output logic        halted,
   output logic [31:0] instret
);

   localparam logic [1:0] S_BOOT  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_EXEC  = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   // Last counter value at which a missing ack still leaves the fetch alive.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] instret_q, instret_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mis_q, mis_d;
   logic        ferr_q, ferr_d;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      instret_d = instret_q;
      cnt_d     = cnt_q;
      mis_d     = mis_q;
      ferr_d    = ferr_q;
      case (state_q)
         S_BOOT:  state_d = S_FETCH;
         S_FETCH: begin
            // An ack arriving on the final allowed cycle still wins over the timeout.
            if (if_ack) begin
               inst_d  = if_rdata;
               cnt_d   = '0;
               state_d = S_EXEC;
            end else if (cnt_q == TO_LAST) begin
               ferr_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_HALT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_EXEC: begin
            if (!stall) begin
               if (npc_in[1:0] == 2'b00) begin
                  pc_d      = npc_in;
                  instret_d = instret_q + 32'd1;
                  state_d   = S_FETCH;
               end else begin
                  mis_d   = 1'b1;
                  state_d = S_HALT;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         state_q   <= S_BOOT;
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         instret_q <= '0;
         cnt_q     <= '0;
         mis_q     <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         instret_q <= instret_d;
         cnt_q     <= cnt_d;
         mis_q     <= mis_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      if (is_jalr)                         npc_op = 2'b10;
      else if (is_jal || (is_branch && br_taken)) npc_op = 2'b01;
      else                                 npc_op = 2'b00;
   end

   assign if_req       = (state_q == S_FETCH);
   assign inst_valid   = (state_q == S_EXEC);
   assign halted       = (state_q == S_HALT);
   assign if_addr      = pc_q;
   assign pc           = pc_q;
   assign inst         = inst_q;
   assign instret      = instret_q;
   assign misalign_exc = mis_q;
   assign fetch_err    = ferr_q;

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Program-counter sequencer for the miniRV core.
- Owns the PC register and runs a fetch/execute loop against a variable-latency instruction port.
- Drives the 2-bit select of the next-PC unit and commits that unit's result back into PC.
- Detects misaligned targets and fetch timeouts, halts on either, and keeps a retired-instruction count.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles to wait for if_ack before fetch error (range 1..255)

Ports:
cpu_clk  in  1  clock, rising edge
cpu_rst  in  1  asynchronous, active-high reset
if_req  out  1  instruction fetch request
if_addr  out  32  fetch address, always equals pc
if_ack  in  1  one-cycle pulse, if_rdata valid
if_rdata  in  32  fetched instruction
is_branch  in  1  decoded conditional branch
br_taken  in  1  branch condition true
is_jal  in  1  decoded jal
is_jalr  in  1  decoded jalr
stall  in  1  hold current instruction in EXEC
npc_in  in  32  next PC from next-PC unit
npc_op  out  2  select to next-PC unit: 00 pc+4, 01 pc+imm, 10 {alu_c[31:1],0}
pc  out  32  current PC (to next-PC unit and datapath)
inst  out  32  latched instruction
inst_valid  out  1  inst is executing this cycle
misalign_exc  out  1  sticky: committed target had npc_in[1:0]!=0
fetch_err  out  1  sticky: if_ack not seen within TIMEOUT cycles
halted  out  1  core is in HALT
instret  out  32  retired-instruction count

Behaviour:
- Reset (async, active-high, any state, including mid-fetch):
  - state=BOOT, pc=RESET_PC, inst=0, instret=0, timeout counter=0.
  - if_req, inst_valid, misalign_exc, fetch_err, halted all 0.
  - An in-flight fetch is abandoned; a late if_ack is ignored.
- States: BOOT, FETCH, EXEC, HALT. All outputs are registered except if_addr (=pc) and npc_op.
- BOOT: one cycle, then FETCH.
- FETCH:
  - if_req=1.
  - Timeout counter increments each cycle without if_ack.
  - On if_ack: inst<=if_rdata, counter<=0, go to EXEC. Fetch latency is therefore ≥1 cycle after if_req rises.
  - If the counter reaches TIMEOUT without ack: fetch_err<=1, go to HALT.
  - An if_ack in the same cycle the counter would reach TIMEOUT wins, i.e. the fetch succeeds.
- EXEC:
  - inst_valid=1, if_req=0.
  - npc_op, combinational, priority jalr > jal > taken branch:
    - is_jalr → 10
    - else is_jal or (is_branch & br_taken) → 01
    - else → 00
    - Invalid combinations resolve by this priority; 2'b11 is never driven.
  - stall=1: stay in EXEC; pc, inst and instret are held; inst_valid stays 1.
  - stall=0 and npc_in[1:0]==0: pc<=npc_in, instret<=instret+1 (wraps at 2^32), go to FETCH. inst_valid drops the next cycle.
  - stall=0 and npc_in[1:0]!=0: misalign_exc<=1, pc held at the faulting instruction, instret not incremented, go to HALT.
- HALT:
  - if_req=0, inst_valid=0, halted=1.
  - Sticky until reset; all inputs ignored.
- if_ack outside FETCH: ignored.
- if_ack while stall: no effect, since stall only matters in EXEC.
- Throughput without stalls: fetch latency + 1 cycles per instruction; with a 1-cycle ack, one instruction every 2 cycles.

Test Plan:
- Sequential flow: reset, RESET_PC=0; if_ack one cycle after every if_req; instructions are non-control; npc_in=pc+4 → if_addr sequence 0,4,8,C; instret=4 after 8 cycles; npc_op=00 throughout.
- Taken branch: at pc=0x10, is_branch=1, br_taken=1, npc_in=0x40 → npc_op=01; next if_addr=0x40. Repeat with br_taken=0, npc_in=0x14 → npc_op=00; next if_addr=0x14.
- jalr priority and misalignment:
  - is_jalr=1 with is_jal=1 → npc_op=10.
  - npc_in=0x102 → misalign_exc=1, halted=1, pc stays 0x20, instret unchanged, if_req stays 0 thereafter.
- Stall: hold stall=1 for 3 EXEC cycles at pc=0x8 → inst_valid=1 and pc=0x8 for all 3 cycles; instret increments exactly once, after stall drops.
- Timeout: TIMEOUT=4, withhold if_ack → fetch_err=1, halted=1 after 4 FETCH cycles. Separately, ack on the 4th cycle → normal EXEC, no error.
- Reset mid-fetch: assert cpu_rst while if_req=1 at pc=0x30 → if_req=0 and pc=RESET_PC immediately, without waiting for a clock edge; an if_ack pulsed during BOOT is ignored; the next fetch is at RESET_PC.
